// File: rtl/branch_control_sequencer.sv
// Hardwired control sequencer for fetch and control-transfer instructions
// (branch, jr, jal, nop, halt) with a memory-ready handshake and halt/illegal detection.
module branch_control_sequencer #(
  parameter int              WORD_W  = 32,
  parameter int              ALU_W   = 4,
  parameter logic [ALU_W-1:0] ALU_ADD = 4'd2,
  parameter int              CNT_W   = 16,
  parameter logic [4:0]      OP_BR   = 5'b10010,
  parameter logic [4:0]      OP_JAL  = 5'b10011,
  parameter logic [4:0]      OP_JR   = 5'b10100,
  parameter logic [4:0]      OP_NOP  = 5'b11010,
  parameter logic [4:0]      OP_HALT = 5'b11011
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] ir,
  input  logic              con_ff,
  output logic              PCout,
  output logic              MDRout,
  output logic              Zlowout,
  output logic              Rout,
  output logic              MARin,
  output logic              MDRin,
  output logic              IRin,
  output logic              Yin,
  output logic              Zlowin,
  output logic              PCin,
  output logic              Rin,
  output logic              IncPC,
  output logic              Read,
  output logic              Gra,
  output logic              Cout,
  output logic              con_in,
  output logic              R15_enable,
  output logic [ALU_W-1:0]  CONTROL,
  output logic [3:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [3:0] {
    RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8, ILL = 4'd9
  } state_e;

  typedef enum logic [2:0] {K_BR, K_JAL, K_JR, K_NOP, K_HALT, K_ILL} kind_e;

  typedef struct packed {
    logic pcOut, mdrOut, zlowOut, rOut, marIn, mdrIn, irIn, yIn, zlowIn;
    logic pcIn, rIn, incPc, read, gra, cOut, conIn, r15Enable;
  } strobes_t;

  state_e           state_q;
  kind_e            kind_q;
  strobes_t         strobe_q;
  logic [ALU_W-1:0] control_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic [4:0] opcode;
  logic       unused_ir;
  assign opcode    = ir[WORD_W-1 -: 5];
  assign unused_ir = ^ir[WORD_W-6:0];

  function automatic kind_e decodeOp(input logic [4:0] op);
    if (op == OP_BR)        return K_BR;
    else if (op == OP_JAL)  return K_JAL;
    else if (op == OP_JR)   return K_JR;
    else if (op == OP_NOP)  return K_NOP;
    else if (op == OP_HALT) return K_HALT;
    else                    return K_ILL;
  endfunction

  function automatic strobes_t fetchStrobes();
    strobes_t s;
    s        = '0;
    s.pcOut  = 1'b1;
    s.marIn  = 1'b1;
    s.incPc  = 1'b1;
    s.zlowIn = 1'b1;
    return s;
  endfunction

  // Outputs are registered: each branch loads the strobes of the state being entered.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_q   <= RST;
      kind_q    <= K_NOP;
      strobe_q  <= '0;
      control_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      strobe_q  <= '0;
      control_q <= '0;
      case (state_q)
        RST: begin
          state_q  <= T0;
          strobe_q <= fetchStrobes();
        end
        T0: begin
          state_q          <= T1;
          strobe_q.zlowOut <= 1'b1;
          strobe_q.pcIn    <= 1'b1;
          strobe_q.read    <= 1'b1;
          strobe_q.mdrIn   <= 1'b1;
        end
        T1: begin
          if (mem_ready) begin
            state_q         <= T2;
            strobe_q.mdrOut <= 1'b1;
            strobe_q.irIn   <= 1'b1;
          end else begin
            // Waiting for memory: keep the read going but never reload PC twice.
            strobe_q.zlowOut <= 1'b1;
            strobe_q.read    <= 1'b1;
            strobe_q.mdrIn   <= 1'b1;
          end
        end
        T2: begin
          state_q <= T3;
          kind_q  <= decodeOp(opcode);
          case (decodeOp(opcode))
            K_BR: begin
              strobe_q.gra   <= 1'b1;
              strobe_q.rOut  <= 1'b1;
              strobe_q.conIn <= 1'b1;
            end
            K_JR: begin
              strobe_q.gra  <= 1'b1;
              strobe_q.rOut <= 1'b1;
              strobe_q.pcIn <= 1'b1;
            end
            K_JAL: begin
              strobe_q.pcOut     <= 1'b1;
              strobe_q.r15Enable <= 1'b1;
              strobe_q.rIn       <= 1'b1;
            end
            default: ;
          endcase
        end
        T3: begin
          case (kind_q)
            K_BR: begin
              state_q        <= T4;
              strobe_q.pcOut <= 1'b1;
              strobe_q.yIn   <= 1'b1;
            end
            K_JAL: begin
              state_q       <= T4;
              strobe_q.gra  <= 1'b1;
              strobe_q.rOut <= 1'b1;
              strobe_q.pcIn <= 1'b1;
            end
            K_HALT: begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end
            K_ILL: begin
              state_q   <= ILL;
              illegal_q <= 1'b1;
            end
            default: begin
              state_q  <= T0;
              strobe_q <= fetchStrobes();
              count_q  <= count_q + 1'b1;
            end
          endcase
        end
        T4: begin
          if (kind_q == K_BR) begin
            state_q         <= T5;
            strobe_q.cOut   <= 1'b1;
            strobe_q.zlowIn <= 1'b1;
            control_q       <= ALU_ADD;
          end else begin
            state_q  <= T0;
            strobe_q <= fetchStrobes();
            count_q  <= count_q + 1'b1;
          end
        end
        T5: begin
          state_q          <= T6;
          strobe_q.zlowOut <= 1'b1;
          strobe_q.pcIn    <= con_ff;
        end
        T6: begin
          state_q  <= T0;
          strobe_q <= fetchStrobes();
          count_q  <= count_q + 1'b1;
        end
        HALT:    state_q <= HALT;
        ILL:     state_q <= ILL;
        default: state_q <= RST;
      endcase
    end
  end

  assign PCout       = strobe_q.pcOut;
  assign MDRout      = strobe_q.mdrOut;
  assign Zlowout     = strobe_q.zlowOut;
  assign Rout        = strobe_q.rOut;
  assign MARin       = strobe_q.marIn;
  assign MDRin       = strobe_q.mdrIn;
  assign IRin        = strobe_q.irIn;
  assign Yin         = strobe_q.yIn;
  assign Zlowin      = strobe_q.zlowIn;
  assign PCin        = strobe_q.pcIn;
  assign Rin         = strobe_q.rIn;
  assign IncPC       = strobe_q.incPc;
  assign Read        = strobe_q.read;
  assign Gra         = strobe_q.gra;
  assign Cout        = strobe_q.cOut;
  assign con_in      = strobe_q.conIn;
  assign R15_enable  = strobe_q.r15Enable;
  assign CONTROL     = control_q;
  assign state       = state_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_branch_control_sequencer.sv
// Directed bench for branch_control_sequencer: walks branch, jal, halt, nop and
// illegal sequences cycle by cycle against hand-computed strobe patterns.
module tb_branch_control_sequencer;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        mem_ready;
  logic [31:0] ir;
  logic        con_ff;
  logic        PCout, MDRout, Zlowout, Rout, MARin, MDRin, IRin, Yin, Zlowin;
  logic        PCin, Rin, IncPC, Read, Gra, Cout, con_in, R15_enable;
  logic [3:0]  CONTROL;
  logic [3:0]  state;
  logic        halted, illegal;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  localparam logic [16:0] B_PCOUT   = 17'd1 << 16;
  localparam logic [16:0] B_MDROUT  = 17'd1 << 15;
  localparam logic [16:0] B_ZLOWOUT = 17'd1 << 14;
  localparam logic [16:0] B_ROUT    = 17'd1 << 13;
  localparam logic [16:0] B_MARIN   = 17'd1 << 12;
  localparam logic [16:0] B_MDRIN   = 17'd1 << 11;
  localparam logic [16:0] B_IRIN    = 17'd1 << 10;
  localparam logic [16:0] B_YIN     = 17'd1 << 9;
  localparam logic [16:0] B_ZLOWIN  = 17'd1 << 8;
  localparam logic [16:0] B_PCIN    = 17'd1 << 7;
  localparam logic [16:0] B_RIN     = 17'd1 << 6;
  localparam logic [16:0] B_INCPC   = 17'd1 << 5;
  localparam logic [16:0] B_READ    = 17'd1 << 4;
  localparam logic [16:0] B_GRA     = 17'd1 << 3;
  localparam logic [16:0] B_COUT    = 17'd1 << 2;
  localparam logic [16:0] B_CONIN   = 17'd1 << 1;
  localparam logic [16:0] B_R15     = 17'd1;

  localparam logic [16:0] S_FETCH = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
  localparam logic [16:0] S_T1    = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
  localparam logic [16:0] S_T1W   = B_ZLOWOUT | B_READ | B_MDRIN;
  localparam logic [16:0] S_T2    = B_MDROUT | B_IRIN;

  localparam logic [31:0] IR_BR   = 32'h91000023;
  localparam logic [31:0] IR_JAL  = 32'h98000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_ILL  = 32'hF8000000;

  logic [16:0] strobes;
  assign strobes = {PCout, MDRout, Zlowout, Rout, MARin, MDRin, IRin, Yin, Zlowin,
                    PCin, Rin, IncPC, Read, Gra, Cout, con_in, R15_enable};

  branch_control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .mem_ready(mem_ready), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Rout(Rout),
    .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
    .PCin(PCin), .Rin(Rin), .IncPC(IncPC), .Read(Read), .Gra(Gra), .Cout(Cout),
    .con_in(con_in), .R15_enable(R15_enable), .CONTROL(CONTROL), .state(state),
    .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );

  always #5 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] irVal, input logic conVal,
                               input logic memVal);
    ir        = irVal;
    con_ff    = conVal;
    mem_ready = memVal;
  endtask

  task automatic waitCycle();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic expectCycle(input string tag, input logic [3:0] st,
                             input logic [16:0] stb, input logic [3:0] ctrl);
    waitCycle();
    checkOutput({tag, ".state"}, {28'd0, state}, {28'd0, st});
    checkOutput({tag, ".strobes"}, {15'd0, strobes}, {15'd0, stb});
    checkOutput({tag, ".control"}, {28'd0, CONTROL}, {28'd0, ctrl});
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".state"}, {28'd0, state}, 32'd0);
    checkOutput({tag, ".strobes"}, {15'd0, strobes}, 32'd0);
    checkOutput({tag, ".control"}, {28'd0, CONTROL}, 32'd0);
    checkOutput({tag, ".flags"}, {30'd0, halted, illegal}, 32'd0);
    checkOutput({tag, ".count"}, {16'd0, instr_count}, 32'd0);
  endtask

  initial begin
    Clear = 1'b1;
    applyStimulus(IR_BR, 1'b1, 1'b1);
    waitCycle();
    checkCleared("reset");
    Clear = 1'b0;

    // branch taken
    expectCycle("br1.t0", 4'd1, S_FETCH, 4'd0);
    expectCycle("br1.t1", 4'd2, S_T1, 4'd0);
    expectCycle("br1.t2", 4'd3, S_T2, 4'd0);
    expectCycle("br1.t3", 4'd4, B_GRA | B_ROUT | B_CONIN, 4'd0);
    expectCycle("br1.t4", 4'd5, B_PCOUT | B_YIN, 4'd0);
    expectCycle("br1.t5", 4'd6, B_COUT | B_ZLOWIN, 4'd2);
    expectCycle("br1.t6", 4'd7, B_ZLOWOUT | B_PCIN, 4'd0);
    expectCycle("br1.ret", 4'd1, S_FETCH, 4'd0);
    checkOutput("br1.count", {16'd0, instr_count}, 32'd1);

    // branch not taken
    applyStimulus(IR_BR, 1'b0, 1'b1);
    expectCycle("br0.t1", 4'd2, S_T1, 4'd0);
    expectCycle("br0.t2", 4'd3, S_T2, 4'd0);
    expectCycle("br0.t3", 4'd4, B_GRA | B_ROUT | B_CONIN, 4'd0);
    expectCycle("br0.t4", 4'd5, B_PCOUT | B_YIN, 4'd0);
    expectCycle("br0.t5", 4'd6, B_COUT | B_ZLOWIN, 4'd2);
    expectCycle("br0.t6", 4'd7, B_ZLOWOUT, 4'd0);
    expectCycle("br0.ret", 4'd1, S_FETCH, 4'd0);
    checkOutput("br0.count", {16'd0, instr_count}, 32'd2);

    // memory wait: T1 held for four cycles, PCin only in the first
    applyStimulus(IR_BR, 1'b0, 1'b0);
    expectCycle("wait.t1a", 4'd2, S_T1, 4'd0);
    expectCycle("wait.t1b", 4'd2, S_T1W, 4'd0);
    expectCycle("wait.t1c", 4'd2, S_T1W, 4'd0);
    expectCycle("wait.t1d", 4'd2, S_T1W, 4'd0);
    mem_ready = 1'b1;
    expectCycle("wait.t2", 4'd3, S_T2, 4'd0);
    expectCycle("wait.t3", 4'd4, B_GRA | B_ROUT | B_CONIN, 4'd0);
    expectCycle("wait.t4", 4'd5, B_PCOUT | B_YIN, 4'd0);
    expectCycle("wait.t5", 4'd6, B_COUT | B_ZLOWIN, 4'd2);
    expectCycle("wait.t6", 4'd7, B_ZLOWOUT, 4'd0);
    expectCycle("wait.ret", 4'd1, S_FETCH, 4'd0);
    checkOutput("wait.count", {16'd0, instr_count}, 32'd3);

    // jal
    applyStimulus(IR_JAL, 1'b0, 1'b1);
    expectCycle("jal.t1", 4'd2, S_T1, 4'd0);
    expectCycle("jal.t2", 4'd3, S_T2, 4'd0);
    expectCycle("jal.t3", 4'd4, B_PCOUT | B_R15 | B_RIN, 4'd0);
    expectCycle("jal.t4", 4'd5, B_GRA | B_ROUT | B_PCIN, 4'd0);
    expectCycle("jal.ret", 4'd1, S_FETCH, 4'd0);
    checkOutput("jal.count", {16'd0, instr_count}, 32'd4);

    // halt, then parked for 20 cycles
    applyStimulus(IR_HALT, 1'b0, 1'b1);
    expectCycle("halt.t1", 4'd2, S_T1, 4'd0);
    expectCycle("halt.t2", 4'd3, S_T2, 4'd0);
    expectCycle("halt.t3", 4'd4, 17'd0, 4'd0);
    expectCycle("halt.enter", 4'd8, 17'd0, 4'd0);
    checkOutput("halt.flag", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 20; i++) expectCycle("halt.park", 4'd8, 17'd0, 4'd0);
    checkOutput("halt.count", {16'd0, instr_count}, 32'd4);

    // illegal opcode
    Clear = 1'b1;
    #1;
    checkCleared("clr1");
    applyStimulus(IR_ILL, 1'b0, 1'b1);
    waitCycle();
    Clear = 1'b0;
    expectCycle("ill.t0", 4'd1, S_FETCH, 4'd0);
    expectCycle("ill.t1", 4'd2, S_T1, 4'd0);
    expectCycle("ill.t2", 4'd3, S_T2, 4'd0);
    expectCycle("ill.t3", 4'd4, 17'd0, 4'd0);
    expectCycle("ill.enter", 4'd9, 17'd0, 4'd0);
    checkOutput("ill.flags", {30'd0, halted, illegal}, 32'd1);
    expectCycle("ill.park", 4'd9, 17'd0, 4'd0);

    // nop retires, then a branch is cut off by Clear mid-T4
    Clear = 1'b1;
    #1;
    checkCleared("clr2");
    applyStimulus(IR_NOP, 1'b1, 1'b1);
    waitCycle();
    Clear = 1'b0;
    expectCycle("nop.t0", 4'd1, S_FETCH, 4'd0);
    expectCycle("nop.t1", 4'd2, S_T1, 4'd0);
    expectCycle("nop.t2", 4'd3, S_T2, 4'd0);
    expectCycle("nop.t3", 4'd4, 17'd0, 4'd0);
    expectCycle("nop.ret", 4'd1, S_FETCH, 4'd0);
    checkOutput("nop.count", {16'd0, instr_count}, 32'd1);
    applyStimulus(IR_BR, 1'b1, 1'b1);
    expectCycle("abort.t1", 4'd2, S_T1, 4'd0);
    expectCycle("abort.t2", 4'd3, S_T2, 4'd0);
    expectCycle("abort.t3", 4'd4, B_GRA | B_ROUT | B_CONIN, 4'd0);
    expectCycle("abort.t4", 4'd5, B_PCOUT | B_YIN, 4'd0);
    Clear = 1'b1;
    #1;
    checkCleared("abort.clr");
    waitCycle();
    Clear = 1'b0;
    expectCycle("abort.restart", 4'd1, S_FETCH, 4'd0);
    checkOutput("abort.count", {16'd0, instr_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
